ram_dp_sync_be: RTL and testbench

Synchronous, parametrised dual-port RAM for the RRAM controller's instruction and data buffers. It replaces the asynchronous dual-port array with clocked ports, per-byte write enables, a registered 1-cycle read with valid strobe, and a defined same-address collision policy. A reset-driven sequencer zero-fills the array, so contents are deterministic after every reset. Both ports are fully independent, separate-direction interfaces with no tristates.

---
 rtl/ram_dp_sync_be.sv | 124 ++++++++++++
 tb/tb_ram_dp_sync_be.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_sync_be.sv
// Dual-port synchronous RAM with per-byte write enables, 1-cycle registered reads,
// read-first / port-0-wins collision policy and a reset-driven zero-fill sequencer.
module ram_dp_sync_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int RAM_DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    cs_0,
  input  logic                    we_0,
  input  logic [DATA_WIDTH/8-1:0] be_0,
  input  logic [ADDR_WIDTH-1:0]   address_0,
  input  logic [DATA_WIDTH-1:0]   wdata_0,
  output logic [DATA_WIDTH-1:0]   rdata_0,
  output logic                    rvalid_0,
  output logic                    addr_err_0,
  input  logic                    cs_1,
  input  logic                    we_1,
  input  logic [DATA_WIDTH/8-1:0] be_1,
  input  logic [ADDR_WIDTH-1:0]   address_1,
  input  logic [DATA_WIDTH-1:0]   wdata_1,
  output logic [DATA_WIDTH-1:0]   rdata_1,
  output logic                    rvalid_1,
  output logic                    addr_err_1,
  output logic                    collision
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  init_we;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
  logic                  rvalid0_q, rvalid1_q, err0_q, err1_q, coll_q;

  logic rdy, acc0, acc1, legal0, legal1, wr0, wr1, rd0, rd1, coll_d;

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST_C) state_d = READY;
    end
  end

  // ---- FSM: outputs ----
  always_comb begin
    init_busy = (state_q == INIT);
    init_we   = (state_q == INIT) && !rst;
  end

  // Request qualification; out-of-range addresses never touch the array
  assign rdy    = (state_q == READY);
  assign acc0   = rdy & cs_0;
  assign acc1   = rdy & cs_1;
  assign legal0 = {1'b0, address_0} < DEPTH_C;
  assign legal1 = {1'b0, address_1} < DEPTH_C;
  assign wr0    = acc0 &  we_0 & legal0;
  assign wr1    = acc1 &  we_1 & legal1;
  assign rd0    = acc0 & ~we_0 & legal0;
  assign rd1    = acc1 & ~we_1 & legal1;
  assign coll_d = acc0 & acc1 & legal0 & legal1 & (address_0 == address_1) & (we_0 | we_1);

  // Port 1 bytes are scheduled first so port 0 overrides on shared enabled bytes
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[ptr_q] <= '0;
    end else begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wr1 && be_1[b]) mem[address_1][8*b +: 8] <= wdata_1[8*b +: 8];
        if (wr0 && be_0[b]) mem[address_0][8*b +: 8] <= wdata_0[8*b +: 8];
      end
    end
  end

  // Reads sample the pre-write word at the same edge, giving read-first behaviour
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      err0_q    <= acc0 & ~legal0;
      err1_q    <= acc1 & ~legal1;
      coll_q    <= coll_d;
      if (rd0) rdata0_q <= mem[address_0];
      if (rd1) rdata1_q <= mem[address_1];
    end
  end

  assign rdata_0    = rdata0_q;
  assign rdata_1    = rdata1_q;
  assign rvalid_0   = rvalid0_q;
  assign rvalid_1   = rvalid1_q;
  assign addr_err_0 = err0_q;
  assign addr_err_1 = err1_q;
  assign collision  = coll_q;
endmodule

// File: tb/tb_ram_dp_sync_be.sv
// Directed bench for ram_dp_sync_be: a 64-deep instance for the main paths and a
// 48-deep instance for out-of-range address handling.
module tb_ram_dp_sync_be;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // 64-deep DUT
  logic        cs0, we0, cs1, we1, busy, rv0, rv1, ae0, ae1, coll;
  logic [3:0]  be0, be1;
  logic [5:0]  a0, a1;
  logic [31:0] wd0, wd1, rd0, rd1;

  // 48-deep DUT
  logic        s_cs0, s_we0, s_cs1, s_we1, s_busy, s_rv0, s_rv1, s_ae0, s_ae1, s_coll;
  logic [3:0]  s_be0, s_be1;
  logic [5:0]  s_a0, s_a1;
  logic [31:0] s_wd0, s_wd1, s_rd0, s_rd1;

  ram_dp_sync_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RAM_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .init_busy(busy),
    .cs_0(cs0), .we_0(we0), .be_0(be0), .address_0(a0), .wdata_0(wd0),
    .rdata_0(rd0), .rvalid_0(rv0), .addr_err_0(ae0),
    .cs_1(cs1), .we_1(we1), .be_1(be1), .address_1(a1), .wdata_1(wd1),
    .rdata_1(rd1), .rvalid_1(rv1), .addr_err_1(ae1),
    .collision(coll)
  );

  ram_dp_sync_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RAM_DEPTH(48)) dut48 (
    .clk(clk), .rst(rst), .init_busy(s_busy),
    .cs_0(s_cs0), .we_0(s_we0), .be_0(s_be0), .address_0(s_a0), .wdata_0(s_wd0),
    .rdata_0(s_rd0), .rvalid_0(s_rv0), .addr_err_0(s_ae0),
    .cs_1(s_cs1), .we_1(s_we1), .be_1(s_be1), .address_1(s_a1), .wdata_1(s_wd1),
    .rdata_1(s_rd1), .rvalid_1(s_rv1), .addr_err_1(s_ae1),
    .collision(s_coll)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs0 = 0; we0 = 0; be0 = 0; a0 = 0; wd0 = 0;
    cs1 = 0; we1 = 0; be1 = 0; a1 = 0; wd1 = 0;
    s_cs0 = 0; s_we0 = 0; s_be0 = 0; s_a0 = 0; s_wd0 = 0;
    s_cs1 = 0; s_we1 = 0; s_be1 = 0; s_a1 = 0; s_wd1 = 0;
  endtask

  task automatic wr_p0(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    cs0 = 1; we0 = 1; a0 = a; wd0 = d; be0 = be;
  endtask

  task automatic rd_p1(input logic [5:0] a);
    cs1 = 1; we1 = 0; a1 = a; be1 = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick(); tick();
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL reset_busy got=%b exp=1", busy); end
    nvec++; if ({rv0, rv1, ae0, ae1, coll} !== 5'b0) begin nerr++; $display("FAIL reset_strobes got=%b exp=00000", {rv0, rv1, ae0, ae1, coll}); end
    nvec++; if ({rd0, rd1} !== 64'h0) begin nerr++; $display("FAIL reset_rdata got=%h exp=0", {rd0, rd1}); end
    rst = 0;
    // Requests issued during INIT must be ignored
    wr_p0(6'd3, 32'hFFFF_FFFF, 4'hF);
    rd_p1(6'd3);
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 10) begin
        nvec++; if ({rv1, ae0, ae1, coll} !== 4'b0) begin nerr++; $display("FAIL init_ignored got=%b exp=0000", {rv1, ae0, ae1, coll}); end
      end
      if (i == 63) begin
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL init_busy_63 got=%b exp=1", busy); end
        idle();
      end
      if (i == 64) begin
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL init_busy_64 got=%b exp=0", busy); end
      end
    end
  endtask

  task automatic test_zero_reads();
    logic [5:0] addrs [4] = '{6'd0, 6'd31, 6'd63, 6'd3};
    for (int k = 0; k < 4; k++) begin
      cs0 = 1; we0 = 0; a0 = addrs[k];
      tick();
      nvec++; if (rv0 !== 1'b1 || rd0 !== 32'h0) begin nerr++; $display("FAIL zero_read a=%0d got rv=%b d=%h exp rv=1 d=0", addrs[k], rv0, rd0); end
    end
    idle();
    tick();
    nvec++; if (rv0 !== 1'b0) begin nerr++; $display("FAIL rvalid_idle got=%b exp=0", rv0); end
  endtask

  task automatic test_byte_enable();
    wr_p0(6'd5, 32'hDEAD_BEEF, 4'b1111); tick();
    wr_p0(6'd5, 32'h1122_3344, 4'b0101); tick();
    wr_p0(6'd5, 32'h0000_0000, 4'b0000); tick();
    nvec++; if (ae0 !== 1'b0) begin nerr++; $display("FAIL be0_no_err got=%b exp=0", ae0); end
    idle(); rd_p1(6'd5); tick();
    nvec++; if (rv1 !== 1'b1 || rd1 !== 32'hDE22_BE44) begin nerr++; $display("FAIL byte_enable got rv=%b d=%h exp rv=1 d=de22be44", rv1, rd1); end
    idle(); tick();
    nvec++; if (rv1 !== 1'b0 || rd1 !== 32'hDE22_BE44) begin nerr++; $display("FAIL rdata_hold got rv=%b d=%h exp rv=0 d=de22be44", rv1, rd1); end
  endtask

  task automatic test_ww_collision();
    wr_p0(6'd9, 32'hAAAA_AAAA, 4'b0011);
    cs1 = 1; we1 = 1; a1 = 6'd9; wd1 = 32'hBBBB_BBBB; be1 = 4'b1110;
    tick();
    nvec++; if (coll !== 1'b1) begin nerr++; $display("FAIL ww_coll got=%b exp=1", coll); end
    idle(); cs0 = 1; we0 = 0; a0 = 6'd9; tick();
    nvec++; if (coll !== 1'b0) begin nerr++; $display("FAIL ww_coll_once got=%b exp=0", coll); end
    nvec++; if (rd0 !== 32'hBBBB_AAAA) begin nerr++; $display("FAIL ww_data got=%h exp=bbbbaaaa", rd0); end
    idle();
  endtask

  task automatic test_read_first();
    wr_p0(6'd12, 32'h1, 4'hF); tick();
    wr_p0(6'd12, 32'h2, 4'hF); rd_p1(6'd12); tick();
    nvec++; if (rv1 !== 1'b1 || rd1 !== 32'h1 || coll !== 1'b1) begin nerr++; $display("FAIL read_first got rv=%b d=%h coll=%b exp rv=1 d=1 coll=1", rv1, rd1, coll); end
    idle(); rd_p1(6'd12); tick();
    nvec++; if (rd1 !== 32'h2 || coll !== 1'b0) begin nerr++; $display("FAIL read_after got d=%h coll=%b exp d=2 coll=0", rd1, coll); end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      wr_p0(6'(20 + k), 32'h1000_0000 + k, 4'hF);
      rd_p1(6'(19 + k));
      tick();
      nvec++;
      if (rv1 !== 1'b1 || rd1 !== ((k == 0) ? 32'h0 : 32'h1000_0000 + k - 1)) begin
        nerr++; $display("FAIL b2b k=%0d got rv=%b d=%h", k, rv1, rd1);
      end
    end
    idle();
    cs0 = 1; we0 = 0; a0 = 6'd23; rd_p1(6'd23); tick();
    nvec++; if (coll !== 1'b0 || rd0 !== 32'h1000_0003 || rd1 !== 32'h1000_0003) begin
      nerr++; $display("FAIL rr_same got coll=%b d0=%h d1=%h exp coll=0 d=10000003", coll, rd0, rd1);
    end
    idle();
  endtask

  task automatic test_addr_err();
    s_cs0 = 1; s_we0 = 1; s_a0 = 6'd47; s_wd0 = 32'h4747_4747; s_be0 = 4'hF; tick();
    s_a0 = 6'd50; s_wd0 = 32'hFFFF_FFFF;
    s_cs1 = 1; s_we1 = 0; s_a1 = 6'd47; tick();
    nvec++; if (s_ae0 !== 1'b1 || s_rd1 !== 32'h4747_4747 || s_rv1 !== 1'b1) begin
      nerr++; $display("FAIL err_wr got ae0=%b rv1=%b d1=%h exp ae0=1 rv1=1 d1=47474747", s_ae0, s_rv1, s_rd1);
    end
    idle(); s_cs1 = 1; s_a1 = 6'd50; tick();
    nvec++; if (s_ae0 !== 1'b0) begin nerr++; $display("FAIL err_wr_pulse got=%b exp=0", s_ae0); end
    nvec++; if (s_rv1 !== 1'b0 || s_ae1 !== 1'b1 || s_rd1 !== 32'h4747_4747) begin
      nerr++; $display("FAIL err_rd got rv1=%b ae1=%b d1=%h exp rv1=0 ae1=1 d1=47474747", s_rv1, s_ae1, s_rd1);
    end
    // Both ports on the same illegal address: errors, no collision
    idle();
    s_cs0 = 1; s_we0 = 1; s_a0 = 6'd50; s_be0 = 4'hF; s_wd0 = 32'h1234_5678;
    s_cs1 = 1; s_we1 = 1; s_a1 = 6'd50; s_be1 = 4'hF; s_wd1 = 32'h8765_4321;
    tick();
    nvec++; if (s_coll !== 1'b0 || s_ae0 !== 1'b1 || s_ae1 !== 1'b1) begin
      nerr++; $display("FAIL err_nocoll got coll=%b ae0=%b ae1=%b exp 0 1 1", s_coll, s_ae0, s_ae1);
    end
    idle(); s_cs0 = 1; s_a0 = 6'd47; s_cs1 = 1; s_a1 = 6'd2; tick();
    nvec++; if (s_rd0 !== 32'h4747_4747 || s_rd1 !== 32'h0 || s_ae1 !== 1'b0) begin
      nerr++; $display("FAIL err_mem got d0=%h d1=%h ae1=%b exp 47474747 0 0", s_rd0, s_rd1, s_ae1);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    cs0 = 1; we0 = 0; a0 = 6'd5; tick(); tick();
    nvec++; if (rv0 !== 1'b1 || rd0 !== 32'hDE22_BE44) begin nerr++; $display("FAIL burst_pre got rv=%b d=%h exp rv=1 d=de22be44", rv0, rd0); end
    rst = 1; tick();
    nvec++; if (rv0 !== 1'b0 || busy !== 1'b1 || rd0 !== 32'h0) begin
      nerr++; $display("FAIL burst_rst got rv=%b busy=%b d=%h exp 0 1 0", rv0, busy, rd0);
    end
    rst = 0;
    wr_p0(6'd7, 32'hFFFF_FFFF, 4'hF);
    for (int i = 1; i <= 20; i++) tick();
    // Second reset at cycle 20 of INIT
    rst = 1; rd_p1(6'd7); tick();
    rst = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 1) begin
        nvec++; if (rv1 !== 1'b0 || rv0 !== 1'b0) begin nerr++; $display("FAIL init_rv got rv0=%b rv1=%b exp 0 0", rv0, rv1); end
      end
      if (i == 63) begin
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL reinit_busy_63 got=%b exp=1", busy); end
        idle();
      end
      if (i == 64) begin
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reinit_busy_64 got=%b exp=0", busy); end
      end
    end
    cs0 = 1; we0 = 0; a0 = 6'd5; rd_p1(6'd7); tick();
    nvec++; if (rv0 !== 1'b1 || rd0 !== 32'h0 || rv1 !== 1'b1 || rd1 !== 32'h0) begin
      nerr++; $display("FAIL reinit_data got rv0=%b d0=%h rv1=%b d1=%h exp 1 0 1 0", rv0, rd0, rv1, rd1);
    end
    idle(); tick();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_zero_reads();
    test_byte_enable();
    test_ww_collision();
    test_read_first();
    test_back_to_back();
    test_addr_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
